// File: rtl/c5_mem_port_if.sv
// Core-side load/store bus and block-RAM port of c5_mem_port, bundled as one interface.
// slave: the memory port itself. master: the core together with the RAM it fronts.
interface c5_mem_port_if;
    logic        I_req;
    logic        I_wr;
    logic [1:0]  I_size;
    logic        I_unsigned;
    logic [31:0] I_adr;
    logic [31:0] I_wdat;
    logic        O_ack;
    logic        O_err;
    logic [31:0] O_rdat;
    logic        O_busy;
    logic        O_ram_stb;
    logic [3:0]  O_ram_we;
    logic [31:0] O_ram_adr;
    logic [31:0] O_ram_dat;
    logic [31:0] I_ram_dat;

    modport slave (
        input  I_req, I_wr, I_size, I_unsigned, I_adr, I_wdat, I_ram_dat,
        output O_ack, O_err, O_rdat, O_busy, O_ram_stb, O_ram_we, O_ram_adr, O_ram_dat
    );

    modport master (
        output I_req, I_wr, I_size, I_unsigned, I_adr, I_wdat, I_ram_dat,
        input  O_ack, O_err, O_rdat, O_busy, O_ram_stb, O_ram_we, O_ram_adr, O_ram_dat
    );
endinterface

// File: rtl/c5_mem_port.sv
// C5 load/store front-end onto a byte-enable block RAM with one-cycle registered read.
// Define C5_MISALIGN_TRAP_EN to reject misaligned half/word accesses instead of masking the low address bits.
module c5_mem_port #(
    parameter int RAM_BYTES = 32768
) (
    input  logic          I_clk,
    input  logic          I_rstn,
    c5_mem_port_if.slave  bus
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_RDATA  = 2'd2;

    logic [1:0]  state_reg;
    logic        wr_reg;
    logic        unsigned_reg;
    logic [1:0]  size_reg;
    logic [1:0]  lane_reg;
    logic        ack_reg;
    logic        err_reg;
    logic        busy_reg;
    logic        stb_reg;
    logic [3:0]  we_reg;
    logic [31:0] rdat_reg;
    logic [31:0] ram_adr_reg;
    logic [31:0] ram_dat_reg;

    logic        misalign;
    logic        req_err;
    logic        accept;
    logic [3:0]  lane_hit;
    logic [3:0]  we_next;
    logic [31:0] dat_next;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] rdat_next;

`ifdef C5_MISALIGN_TRAP_EN
    assign misalign = ((bus.I_size == 2'b01) && bus.I_adr[0]) ||
                      ((bus.I_size == 2'b10) && (bus.I_adr[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    assign req_err = (bus.I_size == 2'b11) || (bus.I_adr >= 32'(RAM_BYTES)) || misalign;
    // The ack cycle doubles as bus turnaround, so a still-asserted request is not re-taken then.
    assign accept  = (state_reg == ST_IDLE) && bus.I_req && !ack_reg;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            localparam logic [1:0] LANE = 2'(gi);
            assign lane_hit[gi] = (bus.I_size == 2'b10) ||
                                  ((bus.I_size == 2'b01) && (bus.I_adr[1] == LANE[1])) ||
                                  ((bus.I_size == 2'b00) && (bus.I_adr[1:0] == LANE));
            assign we_next[gi]  = bus.I_wr && lane_hit[gi];
            assign dat_next[8*gi +: 8] = (bus.I_size == 2'b00) ? bus.I_wdat[7:0] :
                                         (bus.I_size == 2'b01) ? bus.I_wdat[8*(gi%2) +: 8] :
                                                                 bus.I_wdat[8*gi +: 8];
        end
    endgenerate

    always_comb begin
        rd_byte   = bus.I_ram_dat[{lane_reg, 3'b000} +: 8];
        rd_half   = lane_reg[1] ? bus.I_ram_dat[31:16] : bus.I_ram_dat[15:0];
        rdat_next = bus.I_ram_dat;
        case (size_reg)
            2'b00:   rdat_next = {{24{~unsigned_reg & rd_byte[7]}}, rd_byte};
            2'b01:   rdat_next = {{16{~unsigned_reg & rd_half[15]}}, rd_half};
            default: rdat_next = bus.I_ram_dat;
        endcase
    end

    always_ff @(posedge I_clk) begin
        if (!I_rstn) begin
            state_reg    <= ST_IDLE;
            wr_reg       <= 1'b0;
            unsigned_reg <= 1'b0;
            size_reg     <= 2'b00;
            lane_reg     <= 2'b00;
            ack_reg      <= 1'b0;
            err_reg      <= 1'b0;
            busy_reg     <= 1'b0;
            stb_reg      <= 1'b0;
            we_reg       <= 4'b0000;
            rdat_reg     <= 32'd0;
            ram_adr_reg  <= 32'd0;
            ram_dat_reg  <= 32'd0;
        end else begin
            ack_reg <= 1'b0;
            err_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (accept) begin
                        if (req_err) begin
                            ack_reg <= 1'b1;
                            err_reg <= 1'b1;
                        end else begin
                            state_reg    <= ST_ACCESS;
                            busy_reg     <= 1'b1;
                            stb_reg      <= 1'b1;
                            we_reg       <= we_next;
                            ram_adr_reg  <= {bus.I_adr[31:2], 2'b00};
                            ram_dat_reg  <= dat_next;
                            wr_reg       <= bus.I_wr;
                            size_reg     <= bus.I_size;
                            unsigned_reg <= bus.I_unsigned;
                            lane_reg     <= bus.I_adr[1:0];
                        end
                    end
                end
                ST_ACCESS: begin
                    stb_reg <= 1'b0;
                    we_reg  <= 4'b0000;
                    if (wr_reg) begin
                        state_reg <= ST_IDLE;
                        busy_reg  <= 1'b0;
                        ack_reg   <= 1'b1;
                    end else begin
                        state_reg <= ST_RDATA;
                    end
                end
                ST_RDATA: begin
                    rdat_reg  <= rdat_next;
                    ack_reg   <= 1'b1;
                    state_reg <= ST_IDLE;
                    busy_reg  <= 1'b0;
                end
                default: begin
                    state_reg <= ST_IDLE;
                    busy_reg  <= 1'b0;
                    stb_reg   <= 1'b0;
                    we_reg    <= 4'b0000;
                end
            endcase
        end
    end

    assign bus.O_ack     = ack_reg;
    assign bus.O_err     = err_reg;
    assign bus.O_rdat    = rdat_reg;
    assign bus.O_busy    = busy_reg;
    assign bus.O_ram_stb = stb_reg;
    assign bus.O_ram_we  = we_reg;
    assign bus.O_ram_adr = ram_adr_reg;
    assign bus.O_ram_dat = ram_dat_reg;

endmodule

// File: tb/tb_c5_mem_port.sv
// Bench for c5_mem_port: byte-array reference memory, queued expectations for acks and RAM strobes.
`timescale 1ns/1ps
module tb_c5_mem_port;

    localparam int RAM_BYTES = 32768;
    localparam int RAM_WORDS = RAM_BYTES / 4;
`ifdef C5_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic I_clk  = 1'b0;
    logic I_rstn = 1'b0;

    c5_mem_port_if bus();

    c5_mem_port #(.RAM_BYTES(RAM_BYTES)) dut (
        .I_clk  (I_clk),
        .I_rstn (I_rstn),
        .bus    (bus)
    );

    always #5 I_clk = ~I_clk;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;
    always @(posedge I_clk) cyc <= cyc + 1;

    // Block RAM stand-in: byte-enable write, registered read.
    logic [31:0] ram [RAM_WORDS] = '{default: 32'd0};
    logic [31:0] ram_q = 32'd0;
    always @(posedge I_clk) begin
        if (bus.O_ram_stb) begin
            automatic int idx = int'(bus.O_ram_adr >> 2) % RAM_WORDS;
            for (int l = 0; l < 4; l++)
                if (bus.O_ram_we[l]) ram[idx][8*l +: 8] <= bus.O_ram_dat[8*l +: 8];
            ram_q <= ram[idx];
        end
    end
    assign bus.I_ram_dat = ram_q;

    // Reference memory, byte addressed.
    byte unsigned mem_model [RAM_BYTES];

    typedef struct {
        logic        err;
        logic        is_load;
        logic [31:0] rdat;
        int          ack_cyc;
        int          id;
    } ack_t;

    typedef struct {
        logic [31:0] adr;
        logic [3:0]  we;
        logic [31:0] dat;
        logic        is_store;
    } stb_t;

    ack_t ack_q[$];
    stb_t stb_q[$];

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endfunction

    always @(negedge I_clk) begin : monitor
        ack_t ea;
        stb_t es;
        if (I_rstn) begin
            if (bus.O_ack) begin
                if (ack_q.size() == 0) begin
                    n_cmp++; n_fail++;
                    $display("FAIL ack_unexpected: got ack at cycle %0d, required none", cyc);
                end else begin
                    ea = ack_q.pop_front();
                    chk("ack_cycle", cyc, ea.ack_cyc);
                    chk("err", {31'd0, bus.O_err}, {31'd0, ea.err});
                    if (ea.is_load && !ea.err) chk("rdat", bus.O_rdat, ea.rdat);
                    $display("txn %0d: ack cyc=%0d err=%0b load=%0b rdat=%h", ea.id, cyc, bus.O_err, ea.is_load, bus.O_rdat);
                end
            end else if (bus.O_err) begin
                n_cmp++; n_fail++;
                $display("FAIL err_without_ack: got O_err=1 at cycle %0d, required 0", cyc);
            end
            if (bus.O_ram_stb) begin
                if (stb_q.size() == 0) begin
                    n_cmp++; n_fail++;
                    $display("FAIL stb_unexpected: got strobe adr=%h at cycle %0d, required none", bus.O_ram_adr, cyc);
                end else begin
                    es = stb_q.pop_front();
                    chk("ram_adr", bus.O_ram_adr, es.adr);
                    chk("ram_we", {28'd0, bus.O_ram_we}, {28'd0, es.we});
                    if (es.is_store) chk("ram_dat", bus.O_ram_dat, es.dat);
                end
            end
        end
    end

    bit b2b    = 1'b0;
    int txn_id = 0;

    // Called at a negedge: computes the expected outcome from the memory model and drives the request.
    task automatic issue(input logic wr, input logic [1:0] size, input logic uns,
                         input logic [31:0] adr, input logic [31:0] wdat);
        ack_t ea;
        stb_t es;
        int nb;
        int base;
        logic [31:0] v;
        logic err;
        err = (size == 2'b11) || (adr >= 32'(RAM_BYTES)) ||
              (TRAP && (((size == 2'b01) && adr[0]) || ((size == 2'b10) && (adr[1:0] != 2'b00))));
        ea.err = err; ea.is_load = !wr; ea.rdat = 32'd0; ea.id = txn_id;
        ea.ack_cyc = (b2b ? cyc + 1 : cyc) + (err ? 1 : (wr ? 2 : 3));
        es.adr = {adr[31:2], 2'b00}; es.we = 4'b0000; es.dat = 32'd0; es.is_store = wr;
        if (!err) begin
            nb   = 1 << size;
            base = int'(adr) & ~(nb - 1);
            if (wr) begin
                for (int k = 0; k < nb; k++) begin
                    mem_model[base + k] = wdat[8*k +: 8];
                    es.we[(base % 4) + k] = 1'b1;
                end
                for (int i = 0; i < 4; i++) es.dat[8*i +: 8] = wdat[8*(i % nb) +: 8];
            end else begin
                v = 32'd0;
                for (int k = 0; k < nb; k++) v[8*k +: 8] = mem_model[base + k];
                if (!uns && nb < 4 && v[8*nb - 1]) v = v | ~((32'd1 << (8*nb)) - 32'd1);
                ea.rdat = v;
            end
            stb_q.push_back(es);
        end
        ack_q.push_back(ea);
        bus.I_req = 1'b1; bus.I_wr = wr; bus.I_size = size; bus.I_unsigned = uns;
        bus.I_adr = adr;  bus.I_wdat = wdat;
        txn_id++;
    endtask

    task automatic wait_ack();
        bit got;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge I_clk);
            if (bus.O_ack) begin got = 1'b1; break; end
        end
        if (!got) begin
            n_cmp++; n_fail++;
            $display("FAIL ack_timeout: got no ack within 20 cycles, required one");
            ack_q.delete(); stb_q.delete();
            bus.I_req = 1'b0;
            b2b = 1'b0;
        end else begin
            b2b = 1'b1;
        end
    endtask

    task automatic txn(input logic wr, input logic [1:0] size, input logic uns,
                       input logic [31:0] adr, input logic [31:0] wdat);
        issue(wr, size, uns, adr, wdat);
        wait_ack();
    endtask

    task automatic idle(input int n);
        bus.I_req = 1'b0;
        repeat (n) @(negedge I_clk);
        b2b = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ack"},  {31'd0, bus.O_ack},     32'd0);
        chk({tag, "_err"},  {31'd0, bus.O_err},     32'd0);
        chk({tag, "_busy"}, {31'd0, bus.O_busy},    32'd0);
        chk({tag, "_stb"},  {31'd0, bus.O_ram_stb}, 32'd0);
        chk({tag, "_we"},   {28'd0, bus.O_ram_we},  32'd0);
        chk({tag, "_rdat"}, bus.O_rdat,             32'd0);
        chk({tag, "_radr"}, bus.O_ram_adr,          32'd0);
        chk({tag, "_rdat_out"}, bus.O_ram_dat,      32'd0);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation still running at 2 ms, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        logic        wr, uns;
        logic [1:0]  size;
        logic [31:0] adr;
        int          r;

        bus.I_req = 1'b1; bus.I_wr = 1'b1; bus.I_size = 2'b10; bus.I_unsigned = 1'b0;
        bus.I_adr = 32'h0; bus.I_wdat = 32'h1234_5678;
        I_rstn = 1'b0;
        repeat (2) @(posedge I_clk);
        @(negedge I_clk);
        chk_all_zero("reset");
        bus.I_req = 1'b0;
        I_rstn = 1'b1;
        idle(2);

        txn(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF);
        txn(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        idle(1);
        txn(1'b1, 2'b00, 1'b0, 32'h13, 32'h0000_00A5);
        txn(1'b0, 2'b00, 1'b0, 32'h13, 32'h0);
        txn(1'b0, 2'b00, 1'b1, 32'h13, 32'h0);
        txn(1'b1, 2'b10, 1'b0, 32'h20, 32'h8001_1234);
        txn(1'b0, 2'b01, 1'b0, 32'h22, 32'h0);
        txn(1'b0, 2'b01, 1'b1, 32'h20, 32'h0);
        idle(2);
        txn(1'b0, 2'b01, 1'b0, 32'h11, 32'h0);
        txn(1'b1, 2'b01, 1'b0, 32'h11, 32'h0000_C3C4);
        txn(1'b0, 2'b10, 1'b1, 32'h12, 32'h0);
        txn(1'b0, 2'b10, 1'b0, 32'(RAM_BYTES), 32'h0);
        txn(1'b1, 2'b11, 1'b0, 32'h30, 32'hFFFF_FFFF);
        txn(1'b1, 2'b00, 1'b0, 32'(RAM_BYTES - 1), 32'h0000_007E);
        txn(1'b0, 2'b00, 1'b0, 32'(RAM_BYTES - 1), 32'h0);

        // Reset while the load sits in RDATA: the ack must never appear.
        idle(2);
        issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        repeat (2) @(negedge I_clk);
        I_rstn = 1'b0;
        bus.I_req = 1'b0;
        @(negedge I_clk);
        chk("rst_rdata_ack",  {31'd0, bus.O_ack},  32'd0);
        chk("rst_rdata_busy", {31'd0, bus.O_busy}, 32'd0);
        chk("rst_rdata_stb",  {31'd0, bus.O_ram_stb}, 32'd0);
        ack_q.delete();
        stb_q.delete();
        I_rstn = 1'b1;
        idle(3);
        txn(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);

        for (int t = 0; t < 250; t++) begin
            wr   = 1'($urandom_range(0, 1));
            uns  = 1'($urandom_range(0, 1));
            r    = int'($urandom_range(0, 15));
            size = (r == 0) ? 2'b11 : 2'(r % 3);
            r    = int'($urandom_range(0, 19));
            if (r == 0)      adr = 32'(RAM_BYTES) + 32'($urandom_range(0, 64));
            else if (r == 1) adr = 32'(RAM_BYTES - 1) - 32'($urandom_range(0, 7));
            else             adr = 32'($urandom_range(0, 63));
            txn(wr, size, uns, adr, $urandom());
            if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
        end

        idle(5);
        chk("ack_q_drained", 32'(ack_q.size()), 32'd0);
        chk("stb_q_drained", 32'(stb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
